// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
package regfile_ctrl_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

endpackage

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: zero-fills r1..r31 after reset, then
// arbitrates the single write port between core writeback (A) and mul/div (B).
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);
    localparam logic [3:0]        WAIT_MAX = 4'(MAX_WAIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;

    logic a_nz, b_nz, grant_a, grant_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            idx_q      <= ADDR_W'(1);
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        a_nz       = a_valid && (a_rd != '0);
        b_nz       = b_valid && (b_rd != '0);
        grant_a    = 1'b0;
        grant_b    = 1'b0;

        case (state_q)
            INIT: begin
                rf_we_d    = 1'b1;
                rf_rd_d    = idx_q;
                rf_data_d  = '0;
                idx_d      = idx_q + ADDR_W'(1);
                wait_cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Same-rd conflicts go to B first so A's younger value lands last.
                if (a_nz && b_nz) begin
                    if ((a_rd == b_rd) || (wait_cnt_q == WAIT_MAX)) begin
                        grant_b = 1'b1;
                    end else begin
                        grant_a = 1'b1;
                    end
                end else begin
                    grant_a = a_nz;
                    grant_b = b_nz;
                end

                // r0 writes are acknowledged without touching the port.
                a_ready = grant_a || (a_valid && (a_rd == '0));
                b_ready = grant_b || (b_valid && (b_rd == '0));

                if (grant_a) begin
                    rf_we_d   = 1'b1;
                    rf_rd_d   = a_rd;
                    rf_data_d = a_data;
                end else if (grant_b) begin
                    rf_we_d   = 1'b1;
                    rf_rd_d   = b_rd;
                    rf_data_d = b_data;
                end

                if (b_nz && !grant_b) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_data   = rf_data_q;
    assign init_done = (state_q == RUN);

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized scoreboard bench for regfile_wb_ctrl against a cycle-level
// model of the zero-fill sequence and the two-requester arbitration rules.
module tb_regfile_wb_ctrl;

    localparam int unsigned MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_we, init_done;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    regfile_wb_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .init_done(init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        done;
    } port_t;

    typedef struct {
        logic a;
        logic b;
    } rdy_t;

    port_t port_q[$];
    rdy_t  rdy_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          edges_since_reset = 0;
    int          b_denied = 0;
    logic [4:0]  last_rd = '0;
    logic [31:0] last_data = '0;

    // Outstanding requests (held until accepted)
    logic        a_p = 1'b0, b_p = 1'b0;
    logic [4:0]  a_prd = '0, b_prd = '0;
    logic [31:0] a_pdata = '0, b_pdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] pick_rd();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    // mode 0: normal cycle, 1: reset held low, 2: reset asserted mid-cycle
    task automatic step(input int mode);
        rdy_t  r;
        port_t p;
        bit    a_nz, b_nz, win_a, win_b;
        @(negedge clock);
        if (mode == 1) reset = 1'b0;
        else if (mode == 0) reset = 1'b1;
        a_valid = a_p;
        a_rd    = a_p ? a_prd : 5'($urandom);
        a_data  = a_p ? a_pdata : $urandom;
        b_valid = b_p;
        b_rd    = b_p ? b_prd : 5'($urandom);
        b_data  = b_p ? b_pdata : $urandom;

        if (mode != 0) begin
            r = '{a: 1'b0, b: 1'b0};
            p = '{we: 1'b0, rd: '0, data: '0, done: 1'b0};
            edges_since_reset = 0;
            b_denied  = 0;
            last_rd   = '0;
            last_data = '0;
            a_p = 1'b0;
            b_p = 1'b0;
        end else if (edges_since_reset < 31) begin
            edges_since_reset++;
            r = '{a: 1'b0, b: 1'b0};
            p = '{we: 1'b1, rd: 5'(edges_since_reset), data: '0, done: (edges_since_reset == 31)};
            last_rd   = 5'(edges_since_reset);
            last_data = '0;
            b_denied  = 0;
        end else begin
            a_nz  = a_valid && (a_rd != 0);
            b_nz  = b_valid && (b_rd != 0);
            win_a = 0;
            win_b = 0;
            if (a_nz && b_nz) begin
                if (a_rd == b_rd || b_denied == MAX_WAIT) win_b = 1;
                else win_a = 1;
            end else begin
                win_a = a_nz;
                win_b = b_nz;
            end
            r.a = win_a || (a_valid && a_rd == 0);
            r.b = win_b || (b_valid && b_rd == 0);
            if (win_a) begin
                last_rd = a_rd;
                last_data = a_data;
            end else if (win_b) begin
                last_rd = b_rd;
                last_data = b_data;
            end
            p = '{we: (win_a || win_b), rd: last_rd, data: last_data, done: 1'b1};
            if (b_nz && !win_b) b_denied = (b_denied < MAX_WAIT) ? b_denied + 1 : b_denied;
            else b_denied = 0;
            if (r.a) a_p = 1'b0;
            if (r.b) b_p = 1'b0;
        end
        rdy_q.push_back(r);
        port_q.push_back(p);

        if (mode == 2) begin
            #2 reset = 1'b0;
            #1;
            check("async_rst_we", 32'(rf_we), 32'd0);
            check("async_rst_init_done", 32'(init_done), 32'd0);
            check("async_rst_rd", 32'(rf_rd), 32'd0);
        end
    endtask

    task automatic set_a(input logic [4:0] rd, input logic [31:0] data);
        a_p = 1'b1; a_prd = rd; a_pdata = data;
    endtask

    task automatic set_b(input logic [4:0] rd, input logic [31:0] data);
        b_p = 1'b1; b_prd = rd; b_pdata = data;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (a_p || b_p); i++) step(0);
        if (a_p || b_p) check("drain_timeout", 32'(a_p) + 32'(b_p), 32'd0);
        step(0);
    endtask

    // Monitor: readies mid-cycle, write port just after each rising edge
    initial begin
        rdy_t  r;
        port_t p;
        forever begin
            @(negedge clock);
            #3;
            if (rdy_q.size() > 0) begin
                r = rdy_q.pop_front();
                check("a_ready", 32'(a_ready), 32'(r.a));
                check("b_ready", 32'(b_ready), 32'(r.b));
            end
            @(posedge clock);
            #1;
            if (port_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL port_queue_underflow actual=empty required=entry at %0t", $time);
            end else begin
                p = port_q.pop_front();
                check("rf_we", 32'(rf_we), 32'(p.we));
                check("rf_rd", 32'(rf_rd), 32'(p.rd));
                check("rf_data", rf_data, p.data);
                check("init_done", 32'(init_done), 32'(p.done));
            end
        end
    end

    initial begin
        // Reset state and zero-fill, with requests waiting during fill
        repeat (3) step(1);
        set_a(5'd3, 32'h1234_5678);
        set_b(5'd4, 32'h8765_4321);
        repeat (33) step(0);
        drain();

        // A only
        set_a(5'd5, 32'hDEAD_BEEF);
        step(0);
        step(0);

        // r0 drop alongside a B write
        set_a(5'd0, 32'h1);
        set_b(5'd7, 32'h22);
        step(0);
        step(0);

        // Same destination: B then A
        set_a(5'd9, 32'hA);
        set_b(5'd9, 32'hB);
        drain();

        // Starvation: A streams to r1 while B waits on r2
        set_b(5'd2, 32'h55);
        for (int i = 0; i < 9; i++) begin
            if (!a_p) set_a(5'd1, $urandom);
            step(0);
        end
        check("starved_b_served", 32'(b_p), 32'd0);

        // Asynchronous reset while the port is writing, then refill
        if (!a_p) set_a(5'd1, $urandom);
        step(0);
        step(2);
        step(1);
        repeat (32) step(0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!a_p && $urandom_range(0, 99) < 65) set_a(pick_rd(), $urandom);
            if (!b_p && $urandom_range(0, 99) < 45) set_b(pick_rd(), $urandom);
            if (i == 200) step(2);
            else step(0);
        end

        @(posedge clock);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the 32×32 register file: sequences a zero-fill of r1..r31 after reset, then shares the single write port between the core writeback path (requester A) and the long-latency mul/div unit (requester B). It sits between the writeback stage and the register file's write inputs (`RegWrite`, `rd`, `data`). It guarantees one write per cycle, drops writes to r0, and bounds B's starvation.

## Interface
- `MAX_WAIT`, default 4: number of cycles B may be denied before it takes priority (1..15).
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-low.
- `a_valid`, input, 1: core writeback request.
- `a_rd`, input, 5: A destination register.
- `a_data`, input, 32: A write data.
- `a_ready`, output, 1: A accepted this cycle; transfer when `a_valid && a_ready`.
- `b_valid`, input, 1: mul/div request.
- `b_rd`, input, 5: B destination register.
- `b_data`, input, 32: B write data.
- `b_ready`, output, 1: B accepted this cycle.
- `rf_we`, output, 1: register-file write enable (registered).
- `rf_rd`, output, 5: register-file write address (registered).
- `rf_data`, output, 32: register-file write data (registered).
- `init_done`, output, 1: high once zero-fill is complete.

## Operation
- States are INIT and RUN. Reset enters INIT with `idx`=1 and `wait_cnt`=0.
- INIT, on each cycle:
  - issue `rf_we`=1, `rf_rd`=`idx`, `rf_data`=0, then increment `idx`;
  - after `idx`=31 is issued, go to RUN.
  - `a_ready`=`b_ready`=0 throughout.
- RUN arbitration, per cycle, combinational from the current inputs:
  - Writes to r0: `x_ready`=1, no port use, `rf_we` unaffected. The other requester may still be granted in the same cycle.
  - Only one nonzero requester valid: grant it.
  - Both nonzero and `a_rd`==`b_rd`: grant B (older result), stall A. A wins next cycle, so the final value is A's.
  - Both nonzero, different rd: grant A, unless `wait_cnt`==`MAX_WAIT`, in which case grant B.
  - Granted: `x_ready`=1. Ungranted: `x_ready`=0.
- Write port: on a granted nonzero request, the next edge loads `rf_we`=1 and `rf_rd`/`rf_data` from the winner. With no grant, `rf_we`=0 and `rf_rd`/`rf_data` hold their values.
- `wait_cnt`: increments (saturating at `MAX_WAIT`) when `b_valid` is high with nonzero `b_rd` and B is not granted. Clears when B is granted or `b_valid`=0. Holds at 0 in INIT.
- `init_done` is 1 exactly when the state is RUN.
- Reset mid-operation, asynchronous: all state and outputs go to reset values immediately. Zero-fill restarts from r1 and any in-flight request is lost.

## Timing
- Reset values: `rf_we`=0, `rf_rd`=0, `rf_data`=0, `init_done`=0, `a_ready`=0, `b_ready`=0.
- Zero-fill:
  - edge k (k=1..31) after reset release drives the write of rk;
  - the state becomes RUN at edge 31; `init_done`=1 from then on;
  - the first request is granted in the following cycle.
- Accept-to-write latency is 1 cycle: handshake at edge n, `rf_we` high after edge n; the register file commits at edge n+1.
- Port throughput is 1 write per cycle; A-only traffic runs at full rate.
- B worst-case wait is `MAX_WAIT` denied cycles, then a grant on the next cycle.
- No combinational path from `rf_*` back to the inputs. `x_ready` depends combinationally on `x_valid`/`x_rd` of both requesters, the state, and `wait_cnt`.

## Structure
- Shared package `regfile_ctrl_pkg`:
  - state enum {INIT, RUN};
  - `REG_COUNT`=32, `ADDR_W`=5, `DATA_W`=32.
- Single module. The arbitration function is a local combinational block; no sub-module.

## Test plan
- Zero-fill: release reset → `rf_we`=1 for 31 consecutive cycles with `rf_rd`=1..31 and `rf_data`=0; `init_done` rises at edge 31; both readies are 0 before that.
- A only: A writes r5=0xDEADBEEF → `a_ready`=1; next cycle `rf_we`=1, `rf_rd`=5, `rf_data`=0xDEADBEEF.
- r0 drop in parallel: A writes r0=0x1, B writes r7=0x22 in the same cycle → both readies=1; only r7=0x22 reaches the port; no r0 write ever appears.
- Same rd: A r9=0xA, B r9=0xB together → B granted first, A next cycle; port sequence is r9=0xB then r9=0xA.
- Starvation, `MAX_WAIT`=4: A valid every cycle on r1, B valid on r2=0x55 → B denied 4 cycles, granted on the 5th; `wait_cnt` returns to 0; A resumes the following cycle.
- Reset mid-RUN: assert reset while `rf_we`=1 → `rf_we`=0 and `init_done`=0 immediately; on release, zero-fill restarts from r1.
